// File: rtl/potatov_fetch_pkg.sv
// Shared definitions for the instruction fetch front end: memory command
// encodings, fetch FSM states and the default-width buffer entry.
package potatov_fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int CMD_W   = 4;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP = 4'h0,
      CMD_RWA = 4'h1,
      CMD_RWB = 4'h2
   } mem_cmd_t;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

   // Entry layout for a 32-bit PC; the top level builds the same layout at XLEN.
   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Read channel selected by the alternation bit.
   function automatic mem_cmd_t side_cmd(input logic side);
      return side ? CMD_RWB : CMD_RWA;
   endfunction

endpackage

// File: rtl/instruction_prefetch_unit_if.sv
// Memory read handshake, redirect request and decode hand-off of the
// prefetch unit, bundled as one interface.
interface instruction_prefetch_unit_if #(
   parameter int XLEN = 32
);
   logic [3:0]      mem_cmd;
   logic [XLEN-1:0] mem_addr;
   logic            mem_ready;
   logic [31:0]     mem_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_instr;
   logic            out_ready;

   modport master (
      output mem_cmd, mem_addr, out_valid, out_pc, out_instr,
      input  mem_ready, mem_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  mem_cmd, mem_addr, out_valid, out_pc, out_instr,
      output mem_ready, mem_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, instr} entries. Flush clears it in
// one edge; the head entry is read combinationally from the read pointer.
module fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch front end: issues sequential word reads, one at a
// time, alternating read channels, and queues {pc, instr} for decode.
//
// state  | meaning
// INIT   | just out of reset, memory not yet addressed
// ISSUE  | idle, issue a read as soon as the buffer has room
// WAIT   | one read outstanding, push its response when it arrives
// DRAIN  | one read outstanding after a redirect, discard its response
module instruction_prefetch_unit
   import potatov_fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter int              CHANNELS = 2,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'('h800)
) (
   input logic                          clock,
   input logic                          reset,
   instruction_prefetch_unit_if.master  bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = XLEN + INSTR_W;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } buf_entry_t;

   fetch_state_t    state;
   mem_cmd_t        mem_cmd;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] fetch_pc;
   logic            side;

   logic [CW-1:0]   count;
   buf_entry_t      head;
   buf_entry_t      push_entry;
   logic            out_valid;
   logic            push;
   logic            pop;
   logic            flush;
   logic            space_issue;
   logic            space_after_push;
   logic            next_side;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] redirect_aligned;
   logic            unused_redirect_bits;

   assign out_valid        = (count != '0);
   assign pop              = out_valid && bus.out_ready && !bus.redirect_valid;
   assign push             = (state == ST_WAIT) && bus.mem_ready && !bus.redirect_valid;
   assign flush            = bus.redirect_valid;
   assign next_pc          = fetch_pc + XLEN'(4);
   assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_bits = ^bus.redirect_pc[1:0];
   assign next_side        = (CHANNELS == 2) ? ~side : 1'b0;

   // A pop in the same edge frees a slot, so a full buffer can still issue.
   assign space_issue      = (count < CW'(DEPTH)) || pop;
   assign space_after_push = (count < CW'(DEPTH - 1)) || pop;

   assign push_entry.pc    = mem_addr;
   assign push_entry.instr = bus.mem_data;

   fetch_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fetch_buffer (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_data (push_entry),
      .head      (head),
      .count     (count)
   );

   assign bus.mem_cmd   = mem_cmd;
   assign bus.mem_addr  = mem_addr;
   assign bus.out_valid = out_valid;
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;

   // Fetch FSM, PC and command registers; redirect overrides normal flow.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_INIT;
         mem_cmd  <= CMD_NOP;
         mem_addr <= '0;
         fetch_pc <= RESET_PC;
         side     <= 1'b0;
      end else if (bus.redirect_valid) begin
         mem_cmd  <= CMD_NOP;
         fetch_pc <= redirect_aligned;
         case (state)
            ST_WAIT:  state <= bus.mem_ready ? ST_ISSUE : ST_DRAIN;
            // The response being drained may land on this very edge; then
            // nothing is outstanding any more and waiting would never end.
            ST_DRAIN: state <= bus.mem_ready ? ST_ISSUE : ST_DRAIN;
            default:  state <= ST_ISSUE;
         endcase
      end else begin
         mem_cmd <= CMD_NOP;
         case (state)
            ST_INIT: state <= ST_ISSUE;
            ST_ISSUE: begin
               if (space_issue) begin
                  mem_cmd  <= side_cmd(side);
                  mem_addr <= fetch_pc;
                  side     <= next_side;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.mem_ready) begin
                  fetch_pc <= next_pc;
                  if (space_after_push) begin
                     mem_cmd  <= side_cmd(side);
                     mem_addr <= next_pc;
                     side     <= next_side;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
            end
            ST_DRAIN: begin
               if (bus.mem_ready) state <= ST_ISSUE;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed bench for instruction_prefetch_unit: a two-channel instance
// covers fetch, back-pressure, redirects, wrap and reset; a one-channel
// instance covers the single read channel.
module tb_instruction_prefetch_unit;
   import potatov_fetch_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic reset_1 = 1'b1;

   instruction_prefetch_unit_if #(.XLEN(32)) bus ();
   instruction_prefetch_unit_if #(.XLEN(32)) bus_1 ();

   instruction_prefetch_unit #(
      .XLEN(32), .DEPTH(4), .CHANNELS(2), .RESET_PC(32'h800)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   instruction_prefetch_unit #(
      .XLEN(32), .DEPTH(4), .CHANNELS(1), .RESET_PC(32'h800)
   ) dut_1 (
      .clock (clock),
      .reset (reset_1),
      .bus   (bus_1)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One idle cycle after the command, then a single-cycle response.
   task automatic respond(input logic [31:0] data);
      tick();
      bus.mem_ready = 1'b1;
      bus.mem_data  = data;
      tick();
      bus.mem_ready = 1'b0;
   endtask

   task automatic respond_1(input logic [31:0] data);
      tick();
      bus_1.mem_ready = 1'b1;
      bus_1.mem_data  = data;
      tick();
      bus_1.mem_ready = 1'b0;
   endtask

   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_data = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready = 1'b0;
      bus_1.mem_ready = 1'b0;
      bus_1.mem_data = '0;
      bus_1.redirect_valid = 1'b0;
      bus_1.redirect_pc = '0;
      bus_1.out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_cmd", 64'(bus.mem_cmd), 64'(CMD_NOP));
      check("rst_addr", 64'(bus.mem_addr), 64'h0);
      check("rst_valid", 64'(bus.out_valid), 64'h0);

      // Sequential fetch with a ready consumer
      reset = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("init_cmd_nop", 64'(bus.mem_cmd), 64'(CMD_NOP));
      tick();
      check("first_cmd", 64'(bus.mem_cmd), 64'(CMD_RWA));
      check("first_addr", 64'(bus.mem_addr), 64'h800);
      tick();
      check("wait_cmd_nop", 64'(bus.mem_cmd), 64'(CMD_NOP));
      bus.mem_ready = 1'b1;
      bus.mem_data = 32'h1111_0000;
      tick();
      bus.mem_ready = 1'b0;
      check("seq0_valid", 64'(bus.out_valid), 64'h1);
      check("seq0_pc", 64'(bus.out_pc), 64'h800);
      check("seq0_instr", 64'(bus.out_instr), 64'h1111_0000);
      check("seq1_cmd", 64'(bus.mem_cmd), 64'(CMD_RWB));
      check("seq1_addr", 64'(bus.mem_addr), 64'h804);
      respond(32'h2222_0004);
      check("seq1_pc", 64'(bus.out_pc), 64'h804);
      check("seq1_instr", 64'(bus.out_instr), 64'h2222_0004);
      check("seq2_cmd", 64'(bus.mem_cmd), 64'(CMD_RWA));
      check("seq2_addr", 64'(bus.mem_addr), 64'h808);
      respond(32'h3333_0008);
      check("seq2_pc", 64'(bus.out_pc), 64'h808);
      check("seq2_instr", 64'(bus.out_instr), 64'h3333_0008);

      // Back-pressure: exactly DEPTH reads, then one more per pop
      reset = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fill%0d_cmd", i), 64'(bus.mem_cmd), (i % 2 == 0) ? 64'(CMD_RWA) : 64'(CMD_RWB));
         check($sformatf("fill%0d_addr", i), 64'(bus.mem_addr), 64'h800 + 64'(4 * i));
         respond(32'hA000_0000 + 32'(i));
      end
      check("full_cmd_nop", 64'(bus.mem_cmd), 64'(CMD_NOP));
      check("full_head_pc", 64'(bus.out_pc), 64'h800);
      tick();
      tick();
      check("full_hold_nop", 64'(bus.mem_cmd), 64'(CMD_NOP));
      check("full_hold_instr", 64'(bus.out_instr), 64'hA000_0000);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("pop_issue_cmd", 64'(bus.mem_cmd), 64'(CMD_RWA));
      check("pop_issue_addr", 64'(bus.mem_addr), 64'h810);
      check("pop_head_pc", 64'(bus.out_pc), 64'h804);
      tick();
      check("one_more_only", 64'(bus.mem_cmd), 64'(CMD_NOP));

      // Redirect while waiting: late response dropped
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h1002;
      tick();
      bus.redirect_valid = 1'b0;
      check("redir_flush", 64'(bus.out_valid), 64'h0);
      check("redir_cmd_nop", 64'(bus.mem_cmd), 64'(CMD_NOP));
      tick();
      tick();
      bus.mem_ready = 1'b1;
      bus.mem_data = 32'hBAD0_BAD0;
      tick();
      bus.mem_ready = 1'b0;
      check("drain_no_push", 64'(bus.out_valid), 64'h0);
      tick();
      check("redir_cmd", 64'(bus.mem_cmd), 64'(CMD_RWB));
      check("redir_addr", 64'(bus.mem_addr), 64'h1000);
      respond(32'h0000_1234);
      check("redir_pc_out", 64'(bus.out_pc), 64'h1000);
      check("redir_instr_out", 64'(bus.out_instr), 64'h0000_1234);
      tick();

      // Redirect together with a response and a pop
      bus.out_ready = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_data = 32'hDEAD_DEAD;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h2000;
      tick();
      bus.out_ready = 1'b0;
      bus.mem_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      check("same_cycle_empty", 64'(bus.out_valid), 64'h0);
      check("same_cycle_nop", 64'(bus.mem_cmd), 64'(CMD_NOP));
      tick();
      check("same_cycle_cmd", 64'(bus.mem_cmd), 64'(CMD_RWB));
      check("same_cycle_addr", 64'(bus.mem_addr), 64'h2000);
      check("same_cycle_still_empty", 64'(bus.out_valid), 64'h0);
      tick();

      // Redirect to the top of the address space: PC wraps to zero
      bus.mem_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFF;
      tick();
      bus.mem_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      tick();
      check("wrap_first_addr", 64'(bus.mem_addr), 64'hFFFF_FFFC);
      check("wrap_first_cmd", 64'(bus.mem_cmd), 64'(CMD_RWA));
      respond(32'h00C0_FFEE);
      check("wrap_out_pc", 64'(bus.out_pc), 64'hFFFF_FFFC);
      check("wrap_next_addr", 64'(bus.mem_addr), 64'h0);
      check("wrap_next_cmd", 64'(bus.mem_cmd), 64'(CMD_RWB));

      // Reset during WAIT with a late response
      reset = 1'b1;
      bus.mem_ready = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_cmd", 64'(bus.mem_cmd), 64'(CMD_NOP));
      check("mid_rst_valid", 64'(bus.out_valid), 64'h0);
      check("mid_rst_addr", 64'(bus.mem_addr), 64'h0);
      tick();
      bus.mem_ready = 1'b0;
      check("init_ignores_ready", 64'(bus.out_valid), 64'h0);
      tick();
      check("restart_cmd", 64'(bus.mem_cmd), 64'(CMD_RWA));
      check("restart_addr", 64'(bus.mem_addr), 64'h800);

      // Single read channel
      bus_1.out_ready = 1'b1;
      reset_1 = 1'b0;
      tick();
      tick();
      check("ch1_cmd0", 64'(bus_1.mem_cmd), 64'(CMD_RWA));
      check("ch1_addr0", 64'(bus_1.mem_addr), 64'h800);
      respond_1(32'h5555_0000);
      check("ch1_cmd1", 64'(bus_1.mem_cmd), 64'(CMD_RWA));
      check("ch1_addr1", 64'(bus_1.mem_addr), 64'h804);
      check("ch1_out_pc", 64'(bus_1.out_pc), 64'h800);
      respond_1(32'h5555_0004);
      check("ch1_cmd2", 64'(bus_1.mem_cmd), 64'(CMD_RWA));
      check("ch1_addr2", 64'(bus_1.mem_addr), 64'h808);
      check("ch1_out_instr", 64'(bus_1.out_instr), 64'h5555_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
